fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage that owns the program counter and consumes the 2-bit `pc_selection` code produced by `branch_controls`. It issues single-outstanding requests to instruction memory, buffers one fetched instruction for decode under a valid/ready handshake, and on a resolved control transfer redirects the PC, flushes the buffer and discards any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `resolve_valid` in 1: qualifies `pc_selection` as belonging to a resolved instruction this cycle.
- `pc_selection` in 2: 00 sequential, 01 JALR (ALU result), 10 branch/JAL (adder target), 11 treated as 00.
- `branch_target` in 32: adder target for code 10.
- `alu_result` in 32: JALR target for code 01.
- `imem_req` out 1: request; held high until `imem_valid`.
- `imem_addr` out 32: request address; stable while `imem_req` is high.
- `imem_valid` in 1: one-cycle response strobe; may arrive in the same cycle `imem_req` rises.
- `imem_rdata` in 32: instruction word, valid with `imem_valid`.
- `if_valid` out 1: buffer holds an instruction for decode.
- `if_ready` in 1: decode accepts the buffer this cycle.
- `if_instr` out 32: buffered instruction.
- `if_pc` out 32: address of `if_instr`.
- `if_pc_plus4` out 32: `if_pc + 4`, mod 2^32.
- `flush` out 1: one-cycle pulse, registered, the cycle after a redirect.
- `fetch_error` out 1: sticky misaligned-target flag.

## Operation
- Redirect = `resolve_valid` && `pc_selection` ∈ {01, 10}.
- Target selection:
  - 01 → {alu_result[31:1], 1'b0}.
  - 10 → `branch_target`.
- Space = !`if_valid` || `if_ready`.
- States: IDLE (no request outstanding), BUSY (request outstanding, keep result), DRAIN (request outstanding, discard result), HALT.
- IDLE:
  - `imem_req` = space; `imem_addr` = pc.
  - If the request is issued and `imem_valid` is low, latch `req_addr` ← pc and go to BUSY.
  - If `imem_valid` is high in that cycle, the word is accepted directly.
- BUSY: `imem_req` = 1, `imem_addr` = `req_addr`. On `imem_valid`, go to IDLE.
- DRAIN: `imem_req` = 1, `imem_addr` = `req_addr`. On `imem_valid`, discard the word and go to IDLE.
- Accept (valid response in IDLE or BUSY, no redirect):
  - Buffer ← {rdata, pc}; `if_valid` ← 1; pc ← pc + 4.
  - Wrap from 32'hFFFF_FFFC to 0.
- Consume: `if_valid` && `if_ready` with no new accept in that cycle → `if_valid` ← 0.
- Redirect has priority over accept and consume:
  - pc ← target; `if_valid` ← 0; `flush` ← 1.
  - A response arriving in the same cycle is discarded.
  - An outstanding request with no response this cycle → DRAIN.
  - Otherwise → IDLE.
  - Redirect while already in DRAIN: update pc, stay in DRAIN.
- Misaligned target (target[1] = 1 after selection):
  - `fetch_error` ← 1; `flush` pulses.
  - Go to HALT, or DRAIN then HALT if a request is outstanding.
  - HALT: `imem_req` = 0, `if_valid` = 0; exit only by `rst`.
- `rst` in any state (including mid-request):
  - pc ← `RESET_PC`, state IDLE.
  - `if_valid`, `flush` and `fetch_error` ← 0.
  - `imem_req` = 0 during the reset cycle.
  - Any pending memory response is ignored.

## Timing
- First `imem_req` is in the first cycle after `rst` deasserts.
- With a zero-wait memory (`imem_valid` in the request cycle), `if_valid` rises on the next edge.
- With continuous `if_ready`, throughput is 1 instruction per cycle.
- N-cycle memory latency gives throughput of 1 per N+1 cycles; the buffer is empty while a request is outstanding.
- Redirect at edge k: `flush` = 1 in cycle k+1, and the new-target request is issued in cycle k+1.
  - Exception: if draining, the new-target request is issued the cycle after the stale `imem_valid`.
- `imem_req`/`imem_addr` depend combinationally only on state, `if_valid`, `if_ready` and registers; no path from `resolve_valid` or the targets.

## Structure
- Add to `defines.v`:
  - `PC_SEL_SEQ` (2'b00), `PC_SEL_JALR` (2'b01), `PC_SEL_BR` (2'b10).
  - Fetch state encodings `FS_IDLE`, `FS_BUSY`, `FS_DRAIN`, `FS_HALT`.
- One combinational sub-module, `pc_next_select`:
  - Inputs: `pc_selection`, `resolve_valid`, `branch_target`, `alu_result`.
  - Outputs: `redirect`, `target`, `misaligned`.
- FSM, PC, `req_addr` and the buffer live in `fetch_unit`.

## Test plan
1. Reset, then zero-wait memory with `if_ready` = 1 → `imem_addr` sequence 0, 4, 8, 12 on consecutive cycles; `if_pc` follows one cycle later; `if_instr` matches.
2. Hold `if_ready` = 0 with a full buffer for 5 cycles → `imem_req` = 0, `if_instr`/`if_pc` stable. Release → next fetch at `if_pc` + 4.
3. 3-cycle memory; while BUSY at 0x10, redirect 10 with target 0x200 → `flush` pulses; 0x10 data discarded; next request 0x200 issued the cycle after the stale `imem_valid`.
4. Redirect 01 with `alu_result` = 0x0000_0123 → pc = 0x122, so `fetch_error` = 1; HALT entered and `imem_req` stays 0. With `alu_result` = 0x0000_0121 instead → fetch at 0x120, no error.
5. Redirect in the same cycle as `imem_valid` and decode `if_ready` → word dropped, `if_valid` = 0 next cycle, fetch at target.
6. `RESET_PC` = 32'hFFFF_FFFC → first fetch at 0xFFFF_FFFC, next at 0x0000_0000; `rst` asserted during BUSY → `if_valid` 0 and restart at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit shared definitions: pc_selection codes,
// fetch FSM states and a JALR target helper.
package fetch_unit_pkg;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_JALR = 2'b01;
  localparam logic [1:0] PC_SEL_BR   = 2'b10;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_BUSY  = 2'd1,
    FS_DRAIN = 2'd2,
    FS_HALT  = 2'd3
  } fs_t;

  function automatic logic [31:0] jalr_tgt(
    input logic [31:0] a
  );
    return {a[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus and fetch-to-decode
// handshake, bundled for the fetch stage.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_plus4
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4
  );
endinterface

// File: rtl/fetch_unit_pc_next_select.sv
// Decodes pc_selection into a redirect request,
// its target and a misalignment flag.
module pc_next_select
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  pc_selection,
  input  logic        resolve_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_result,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misaligned
);

  logic unused_lsb;
  assign unused_lsb = alu_result[0];

  always_comb begin
    redirect = 1'b0;
    target   = branch_target;
    unique case (1'b1)
      (pc_selection == PC_SEL_JALR): begin
        redirect = resolve_valid;
        target   = jalr_tgt(alu_result);
      end
      (pc_selection == PC_SEL_BR): begin
        redirect = resolve_valid;
        target   = branch_target;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
    misaligned = redirect && target[1];
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, single-outstanding imem
// requests, one-entry decode buffer and redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_valid,
  input  logic [1:0]  pc_selection,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_result,
  fetch_unit_if.master bus,
  output logic        flush,
  output logic        fetch_error
);

  fs_t         state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        buf_valid;
  logic        halt_pend;

  logic        redirect;
  logic [31:0] target;
  logic        misaligned;

  pc_next_select u_sel (
    .pc_selection (pc_selection),
    .resolve_valid(resolve_valid),
    .branch_target(branch_target),
    .alu_result   (alu_result),
    .redirect     (redirect),
    .target       (target),
    .misaligned   (misaligned)
  );

  logic space;
  logic issue;
  logic pend;
  logic take;
  logic keep;
  logic open;

  assign space = !buf_valid || bus.if_ready;
  assign issue = (state == FS_IDLE) && space;
  assign pend  = (state == FS_BUSY)
              || (state == FS_DRAIN);
  assign take  = redirect && (state != FS_HALT);
  assign keep  = bus.imem_valid
              && (issue || state == FS_BUSY);
  // request still in flight after this edge
  assign open  = (issue || pend) && !bus.imem_valid;

  assign bus.imem_req  = !rst && (issue || pend);
  assign bus.imem_addr = (state == FS_IDLE)
                       ? pc : req_addr;

  assign bus.if_valid    = buf_valid;
  assign bus.if_instr    = buf_instr;
  assign bus.if_pc       = buf_pc;
  assign bus.if_pc_plus4 = buf_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FS_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      buf_instr   <= 32'd0;
      buf_pc      <= 32'd0;
      buf_valid   <= 1'b0;
      halt_pend   <= 1'b0;
      flush       <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      flush <= take;
      if (issue) req_addr <= pc;
      if (take) begin
        pc        <= target;
        buf_valid <= 1'b0;
        if (misaligned) begin
          fetch_error <= 1'b1;
          halt_pend   <= 1'b1;
        end
        if (open)
          state <= FS_DRAIN;
        else if (misaligned || halt_pend)
          state <= FS_HALT;
        else
          state <= FS_IDLE;
      end else begin
        if (keep) begin
          buf_instr <= bus.imem_rdata;
          buf_pc    <= pc;
          buf_valid <= 1'b1;
          pc        <= pc + 32'd4;
        end else if (buf_valid && bus.if_ready) begin
          buf_valid <= 1'b0;
        end
        unique case (state)
          FS_IDLE:
            if (issue && !bus.imem_valid)
              state <= FS_BUSY;
          FS_BUSY:
            if (bus.imem_valid)
              state <= FS_IDLE;
          FS_DRAIN:
            if (bus.imem_valid)
              state <= halt_pend ? FS_HALT : FS_IDLE;
          FS_HALT:
            state <= FS_HALT;
          default:
            state <= FS_IDLE;
        endcase
      end
    end
  end

endmodule
